pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 20 ++
 rtl/pc_gen_incr.sv | 14 +
 rtl/pc_gen.sv | 91 +++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-side PC generator: FSM encodings,
// default reset vector and instruction sizing.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } pcState_e;

  localparam int unsigned DEFAULT_WIDTH    = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned INSTR_WIDTH      = 32;
  localparam int unsigned INSTR_BYTES      = INSTR_WIDTH / 8;

  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return |lowBits;
  endfunction

endpackage

// File: rtl/pc_gen_incr.sv
// Sequential-fetch incrementer: address plus one instruction, wrapping
// modulo 2^WIDTH.
module pc_incr
  import pc_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] addr_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = addr_i + WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: issues fetch requests at pc_out and advances
// to the (word-aligned) next-PC candidate once a fetch is accepted.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] npc_in,
  input  logic             stall,
  input  logic             if_ack,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             if_req,
  output logic             misalign,
  output logic [31:0]      fetch_cnt
);

  pcState_e         state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      fetchCnt_q, fetchCnt_d;
  logic             ifReq_q, ifReq_d;
  logic             misalign_q, misalign_d;
  logic             load;

  pc_incr #(.WIDTH(WIDTH)) u_incr (
    .addr_i (pc_q),
    .sum_o  (pc_plus4)
  );

  // An accepted fetch in REQ advances immediately unless stalled; a stalled
  // accept parks in HOLD and advances as soon as the stall clears.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetchCnt_d = fetchCnt_q;
    misalign_d = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (if_ack) begin
          if (stall) state_d = HOLD;
          else       load    = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pc_d       = {npc_in[WIDTH-1:2], 2'b00};
      fetchCnt_d = fetchCnt_q + 32'd1;
      misalign_d = isMisaligned(npc_in[1:0]);
    end

    // if_req is registered from the next state, so if_ack/stall never
    // reach it combinationally.
    ifReq_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fetchCnt_q <= 32'd0;
      ifReq_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetchCnt_q <= fetchCnt_d;
      ifReq_q    <= ifReq_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_out    = pc_q;
  assign if_req    = ifReq_q;
  assign misalign  = misalign_q;
  assign fetch_cnt = fetchCnt_q;

endmodule
